// File: rtl/vga_stream_src_pkg.sv
// vga_stream_src_pkg: 640x480@60 timing defaults, RGB565 colours and counter types shared by the VGA stream source
package vga_stream_src_pkg;
  localparam int CNT_W = 11;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BACK_DEF = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BACK_DEF = 33;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF = 10;
  localparam int H_TOTAL_DEF = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;
  localparam int V_TOTAL_DEF = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [15:0] rgb565_t;
  typedef struct packed {
    logic h_act;
    logic v_act;
    logic hs_raw;
    logic vs_raw;
  } tdec_t;
  localparam rgb565_t RGB_BLACK = 16'h0000;
  localparam rgb565_t RGB_WHITE = 16'hFFFF;
  localparam rgb565_t BAR_COLORS [8] = '{RGB_WHITE, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, RGB_BLACK};
  function automatic rgb565_t bar_color(input logic [2:0] idx);
    return BAR_COLORS[idx];
  endfunction
endpackage

// File: rtl/vga_timing_cnt.sv
// vga_timing_cnt: free-running h/v pixel counters with active-window and sync decode
// Ports: i_clk, i_rst_n (async active-low), o_h_cnt/o_v_cnt (current position),
//        o_dec (h_act, v_act, hs_raw, vs_raw; sync raw flags are active-high)
module vga_timing_cnt
  import vga_stream_src_pkg::*;
#(
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BACK = H_BACK_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BACK = V_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  output cnt_t  o_h_cnt,
  output cnt_t  o_v_cnt,
  output tdec_t o_dec
);
  localparam cnt_t H_LAST = cnt_t'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam cnt_t V_LAST = cnt_t'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam cnt_t H_BEG = cnt_t'(H_SYNC + H_BACK);
  localparam cnt_t H_END = cnt_t'(H_SYNC + H_BACK + H_ACTIVE);
  localparam cnt_t V_BEG = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t V_END = cnt_t'(V_SYNC + V_BACK + V_ACTIVE);
  localparam cnt_t H_SW = cnt_t'(H_SYNC);
  localparam cnt_t V_SW = cnt_t'(V_SYNC);
  cnt_t r_h_cnt, r_v_cnt;
  logic w_h_wrap;
  assign w_h_wrap = r_h_cnt == H_LAST;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
      if (w_h_wrap) r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end
  end
  assign o_h_cnt = r_h_cnt;
  assign o_v_cnt = r_v_cnt;
  assign o_dec.h_act = (r_h_cnt >= H_BEG) && (r_h_cnt < H_END);
  assign o_dec.v_act = (r_v_cnt >= V_BEG) && (r_v_cnt < V_END);
  assign o_dec.hs_raw = r_h_cnt < H_SW;
  assign o_dec.vs_raw = r_v_cnt < V_SW;
endmodule

// File: rtl/vga_stream_src.sv
// vga_stream_src: VGA timing generator that streams RGB565 pixels from a non-show-ahead FIFO
// Ports: vga_clk, rst_n (async active-low); fifo_rd_en/fifo_rd_data/fifo_empty (FIFO read side,
//        data valid the cycle after the request); test_mode (colour bars, only with VGA_COLORBAR_EN);
//        oVGA_hs/oVGA_vs/oVGA_de/oRGB_565 (video out, 1-cycle latency from counters);
//        frame_start (pulse on first output cycle of a frame); underflow (sticky per frame).
// Build option: define VGA_COLORBAR_EN to add the internal colour-bar pattern source.
module vga_stream_src
  import vga_stream_src_pkg::*;
#(
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BACK = H_BACK_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BACK = V_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT = V_FRONT_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  input  logic        fifo_empty,
  input  logic        test_mode,
  output logic        oVGA_hs,
  output logic        oVGA_vs,
  output logic        oVGA_de,
  output logic [15:0] oRGB_565,
  output logic        frame_start,
  output logic        underflow
);
  cnt_t w_h_cnt, w_v_cnt;
  tdec_t w_dec;
  logic w_act, w_starve, w_frame0;
  logic r_hs, r_vs, r_de, r_starved, r_fs, r_uf;
  vga_timing_cnt #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT)
  ) u_cnt (
    .i_clk(vga_clk),
    .i_rst_n(rst_n),
    .o_h_cnt(w_h_cnt),
    .o_v_cnt(w_v_cnt),
    .o_dec(w_dec)
  );
  assign w_act = w_dec.h_act & w_dec.v_act;
  assign w_frame0 = (w_h_cnt == '0) && (w_v_cnt == '0);
  // A read issued on an empty FIFO returns nothing; remember it so the pixel is blanked.
  assign w_starve = fifo_rd_en & fifo_empty;
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs <= ~SYNC_POL;
      r_vs <= ~SYNC_POL;
      r_de <= 1'b0;
      r_starved <= 1'b0;
      r_fs <= 1'b0;
      r_uf <= 1'b0;
    end else begin
      r_hs <= w_dec.hs_raw ? SYNC_POL : ~SYNC_POL;
      r_vs <= w_dec.vs_raw ? SYNC_POL : ~SYNC_POL;
      r_de <= w_act;
      r_starved <= w_starve;
      r_fs <= w_frame0;
      r_uf <= w_starve | (r_uf & ~w_frame0);
    end
  end
`ifdef VGA_COLORBAR_EN
  cnt_t w_x;
  logic [2:0] w_bar_idx;
  logic r_test;
  rgb565_t r_bar;
  assign fifo_rd_en = w_act & ~test_mode;
  assign w_x = w_h_cnt - cnt_t'(H_SYNC + H_BACK);
  // Only meaningful inside the active window; out-of-window values are masked by de.
  assign w_bar_idx = 3'((32'(w_x) * 32'd8) / 32'(H_ACTIVE));
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_test <= 1'b0;
      r_bar <= RGB_BLACK;
    end else begin
      r_test <= test_mode;
      r_bar <= bar_color(w_bar_idx);
    end
  end
  assign oRGB_565 = !r_de ? RGB_BLACK : r_test ? r_bar : r_starved ? RGB_BLACK : fifo_rd_data;
`else
  logic w_unused;
  assign w_unused = test_mode;
  assign fifo_rd_en = w_act;
  assign oRGB_565 = (r_de && !r_starved) ? fifo_rd_data : RGB_BLACK;
`endif
  assign oVGA_hs = r_hs;
  assign oVGA_vs = r_vs;
  assign oVGA_de = r_de;
  assign frame_start = r_fs;
  assign underflow = r_uf;
endmodule

// File: tb/tb_vga_stream_src.sv
// tb_vga_stream_src: self-checking bench for vga_stream_src with a small raster and a position-based model
module tb_vga_stream_src;
  localparam int HS = 4, HB = 3, HA = 16, HF = 2;
  localparam int VS = 2, VB = 2, VA = 6, VF = 1;
  localparam logic POL = 1'b0;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
`ifdef VGA_COLORBAR_EN
  localparam bit CB = 1'b1;
`else
  localparam bit CB = 1'b0;
`endif
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic vga_clk = 1'b0, rst_n = 1'b0, fifo_empty = 1'b0, test_mode = 1'b0;
  logic [15:0] fifo_rd_data = '0;
  logic fifo_rd_en, oVGA_hs, oVGA_vs, oVGA_de, frame_start, underflow;
  logic [15:0] oRGB_565;
  int n_cmp = 0, n_err = 0;
  int p = 0, req_cnt = 0, emp_mode = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
  bit out_valid = 0, prv_req = 0, prv_starve = 0, prv_tm = 0, uf_exp = 0;
  bit inc_mode = 1, tm_rand = 0, first_frame = 1;
  logic [15:0] prv_val = '0;
  typedef struct {int pos; bit hs_a; bit vs_a; bit de; bit fs;} vec_t;
  vec_t tbl [11];

  vga_stream_src #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF), .SYNC_POL(POL)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .test_mode(test_mode), .oVGA_hs(oVGA_hs), .oVGA_vs(oVGA_vs),
    .oVGA_de(oVGA_de), .oRGB_565(oRGB_565), .frame_start(frame_start), .underflow(underflow)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic bit is_act(int x);
    int h = x % HT, v = x / HT;
    return h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t p=%0d)", name, act, exp, $time, p);
    end
  endtask

  task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t p=%0d)", name, act, exp, $time, p);
    end
  endtask

  task automatic chk_reset();
    chk1("rst_hs", oVGA_hs, ~POL);
    chk1("rst_vs", oVGA_vs, ~POL);
    chk1("rst_de", oVGA_de, 1'b0);
    chk16("rst_rgb", oRGB_565, 16'h0000);
    chk1("rst_fs", frame_start, 1'b0);
    chk1("rst_uf", underflow, 1'b0);
  endtask

  // One pixel clock: drive FIFO side, check outputs for the previous position, advance the model.
  task automatic tick();
    int h, v, q, qh, qv;
    bit req, act_q, tm;
    logic [15:0] exp_rgb;
    h = p % HT;
    v = p / HT;
    if (tm_rand) test_mode = 1'($urandom_range(0, 1));
    tm = test_mode & CB;
    req = is_act(p) && !tm;
    fifo_empty = (emp_mode == 1) ? (v == VS + VB + 5 && h >= HS + HB + 10 && h <= HS + HB + 12)
               : (emp_mode == 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
    fifo_rd_data = prv_req ? prv_val : 16'($urandom);
    @(negedge vga_clk);
    chk1("rd_en", fifo_rd_en, req);
    if (!out_valid) chk_reset();
    else begin
      q = (p + FT - 1) % FT;
      qh = q % HT;
      qv = q / HT;
      act_q = is_act(q);
      if (q == 0) uf_exp = 0;
      if (prv_starve) uf_exp = 1;
      exp_rgb = !act_q ? 16'h0000 : prv_tm ? BARS[(qh - HS - HB) * 8 / HA] : prv_starve ? 16'h0000 : prv_val;
      chk1("hs", oVGA_hs, qh < HS ? POL : ~POL);
      chk1("vs", oVGA_vs, qv < VS ? POL : ~POL);
      chk1("de", oVGA_de, act_q);
      chk16("rgb", oRGB_565, exp_rgb);
      chk1("frame_start", frame_start, q == 0);
      chk1("underflow", underflow, uf_exp);
      if (first_frame) begin
        foreach (tbl[i])
          if (tbl[i].pos == q) begin
            chk1("tbl_hs", oVGA_hs, tbl[i].hs_a ? POL : ~POL);
            chk1("tbl_vs", oVGA_vs, tbl[i].vs_a ? POL : ~POL);
            chk1("tbl_de", oVGA_de, tbl[i].de);
            chk1("tbl_fs", frame_start, tbl[i].fs);
          end
        de_cnt += int'(oVGA_de);
        hs_cnt += int'(oVGA_hs == POL);
        vs_cnt += int'(oVGA_vs == POL);
        if (q == FT - 1) begin
          chk16("de_per_frame", 16'(de_cnt), 16'(HA * VA));
          chk16("hs_per_frame", 16'(hs_cnt), 16'(HS * VT));
          chk16("vs_per_frame", 16'(vs_cnt), 16'(VS * HT));
          first_frame = 0;
        end
      end
    end
    prv_req = req;
    prv_starve = req && fifo_empty;
    prv_tm = tm;
    prv_val = inc_mode ? 16'(req_cnt) : 16'($urandom);
    if (req) req_cnt++;
    out_valid = 1;
    @(posedge vga_clk);
    #1;
    p = (p + 1) % FT;
  endtask

  task automatic restart();
    p = 0;
    out_valid = 0;
    prv_req = 0;
    prv_starve = 0;
    prv_tm = 0;
    uf_exp = 0;
  endtask

  initial begin
    tbl = '{'{0, 1, 1, 0, 1}, '{3, 1, 1, 0, 0}, '{4, 0, 1, 0, 0}, '{49, 0, 1, 0, 0},
            '{50, 1, 0, 0, 0}, '{106, 0, 0, 0, 0}, '{107, 0, 0, 1, 0}, '{122, 0, 0, 1, 0},
            '{123, 0, 0, 0, 0}, '{247, 0, 0, 1, 0}, '{257, 0, 0, 0, 0}};
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    chk_reset();
    chk1("rst_rd_en", fifo_rd_en, 1'b0);
    @(posedge vga_clk);
    #1;
    rst_n = 1'b1;
    restart();
    repeat (FT + 1) tick();
    emp_mode = 1;
    repeat (FT) tick();
    emp_mode = 2;
    inc_mode = 0;
    tm_rand = 1;
    repeat (3 * FT) tick();
    tm_rand = 0;
    test_mode = 1'b0;
    for (int i = 0; i < FT && p != 6 * HT + 12; i++) tick();
    rst_n = 1'b0;
    #1;
    chk_reset();
    repeat (5) begin
      @(negedge vga_clk);
      chk_reset();
      chk1("rst_rd_en", fifo_rd_en, 1'b0);
    end
    @(posedge vga_clk);
    #1;
    rst_n = 1'b1;
    restart();
    repeat (FT + 2) tick();
`ifdef VGA_COLORBAR_EN
    test_mode = 1'b1;
    repeat (FT) tick();
    tm_rand = 1;
    repeat (FT) tick();
    tm_rand = 0;
    test_mode = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
